// File: rtl/path_pio_pkg.sv
// Shared definitions for the path/position PIO bank: register map, CTRL bit
// positions and the commit FSM state type.
package path_pio_pkg;

  localparam logic [3:0] ADDR_SHADOW0    = 4'h0;
  localparam logic [3:0] ADDR_IN0        = 4'h4;
  localparam logic [3:0] ADDR_CTRL       = 4'h8;
  localparam logic [3:0] ADDR_IRQ_STATUS = 4'h9;
  localparam logic [3:0] ADDR_IRQ_MASK   = 4'hA;

  localparam int unsigned CTRL_COMMIT_BIT    = 0;
  localparam int unsigned CTRL_IMMEDIATE_BIT = 1;
  localparam int unsigned CTRL_PENDING_BIT   = 0;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY
  } commit_state_t;

endpackage

// File: rtl/path_pio_sync.sv
// One input channel: 2-flop synchroniser, plus a change-detect pulse on the
// synchronised value when PIO_IRQ_EN is defined.
module path_pio_sync #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
`ifdef PIO_IRQ_EN
  output logic         chg_o,
`endif
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

`ifdef PIO_IRQ_EN
  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync_q;
    end
  end

  assign chg_o = (sync_q != prev_q);
`endif

endmodule

// File: rtl/path_pio_bank.sv
// Avalon-MM PIO bank with frame-synchronised atomic output commit.
// Define PIO_IRQ_EN to build the input change-detect interrupt logic.
module path_pio_bank
  import path_pio_pkg::*;
#(
  parameter int unsigned NUM_OUT = 2,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned NUM_IN  = 2,
  parameter int unsigned IN_W    = 10
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [3:0]               avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  input  logic                     frame_sync,
  input  logic [NUM_IN*IN_W-1:0]   in_export,
  output logic [NUM_OUT*OUT_W-1:0] out_export,
  output logic                     irq
);

  commit_state_t    state_q, state_d;
  logic [OUT_W-1:0] shadow_q [NUM_OUT];
  logic [OUT_W-1:0] shadow_d [NUM_OUT];
  logic [OUT_W-1:0] live_q   [NUM_OUT];
  logic [OUT_W-1:0] live_d   [NUM_OUT];
  logic [IN_W-1:0]  in_sync  [NUM_IN];
  logic [31:0]      rdata_q, rdata_d;
  logic             fs_prev_q;
  logic             fs_rise;
  logic             commit;
  logic             immediate;

`ifdef PIO_IRQ_EN
  logic [NUM_IN-1:0] chg;
  logic [NUM_IN-1:0] status_q, status_d;
  logic [NUM_IN-1:0] mask_q, mask_d;
  logic              irq_q;
`endif

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    path_pio_sync #(.W(IN_W)) u_sync (
      .clk_i  (clk_clk),
      .rst_ni (reset_reset_n),
      .d_i    (in_export[g*IN_W +: IN_W]),
`ifdef PIO_IRQ_EN
      .chg_o  (chg[g]),
`endif
      .q_o    (in_sync[g])
    );
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_export[g*OUT_W +: OUT_W] = live_q[g];
  end

  assign fs_rise   = frame_sync & ~fs_prev_q;
  assign commit    = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[CTRL_COMMIT_BIT];
  assign immediate = avs_writedata[CTRL_IMMEDIATE_BIT];

  // A commit arriving during APPLY is not lost: it chains straight into the next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit) state_d = immediate ? APPLY : PENDING;
      PENDING: if (fs_rise || (commit && immediate)) state_d = APPLY;
      APPLY:   state_d = commit ? (immediate ? APPLY : PENDING) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Live copies the pre-edge shadow, so a shadow write on the APPLY edge waits for the next commit.
  always_comb begin
    shadow_d = shadow_q;
    live_d   = live_q;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (avs_write && (avs_address == ADDR_SHADOW0 + 4'(i))) begin
        shadow_d[i] = avs_writedata[OUT_W-1:0];
      end
    end
    if (state_q == APPLY) begin
      live_d = shadow_q;
    end
  end

`ifdef PIO_IRQ_EN
  // Change-detect set takes priority over a same-cycle W1C.
  always_comb begin
    status_d = status_q;
    mask_d   = mask_q;
    if (avs_write && (avs_address == ADDR_IRQ_STATUS)) begin
      status_d = status_q & ~avs_writedata[NUM_IN-1:0];
    end
    status_d = status_d | chg;
    if (avs_write && (avs_address == ADDR_IRQ_MASK)) begin
      mask_d = avs_writedata[NUM_IN-1:0];
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (avs_address == ADDR_SHADOW0 + 4'(i)) rdata_d[OUT_W-1:0] = shadow_q[i];
    end
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (avs_address == ADDR_IN0 + 4'(i)) rdata_d[IN_W-1:0] = in_sync[i];
    end
    if (avs_address == ADDR_CTRL) rdata_d[CTRL_PENDING_BIT] = (state_q != IDLE);
`ifdef PIO_IRQ_EN
    if (avs_address == ADDR_IRQ_STATUS) rdata_d[NUM_IN-1:0] = status_q;
    if (avs_address == ADDR_IRQ_MASK)   rdata_d[NUM_IN-1:0] = mask_q;
`endif
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      shadow_q  <= '{default: '0};
      live_q    <= '{default: '0};
      rdata_q   <= '0;
      fs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      fs_prev_q <= frame_sync;
      if (avs_read) rdata_q <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;

`ifdef PIO_IRQ_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      irq_q    <= |(status_q & mask_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
